exported_class_method_template: RTL and testbench
=================================================

Name: exported_class_method_template

Overview:
- Hardware export of a class method `TimesFive(uint32 x) -> uint32`, returning x*5 modulo 2^32.
- Input side is a ready/valid call port; output side is a show-ahead FIFO read port.
- Includes a reset/startup sequencer and an optional stall-injection hook for verification.
- Sits as a leaf accelerator driven by host-side mailbox adapters.

Parameters:
- FIFO_DEPTH, 32, result FIFO entries; power of two, at least 4.
- STARTUP_CYCLES, 8, cycles after reset release before rst_and_startup_done_out rises.
- STALL_W, 3, width of stall_rate_in.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- rst_and_startup_done_out  out  1  high once reset is released and startup has completed.
- TimesFive___uint_32___valid_in  in  1  call request valid.
- TimesFive___uint_32___x_in  in  32  argument x.
- TimesFive___uint_32___rdy_out  out  1  call can be accepted.
- TimesFive___uint_32___rden_in  in  1  pop result.
- TimesFive___uint_32___empty_out  out  1  no result available.
- TimesFive___uint_32___result_out  out  32  head-of-FIFO result.
- stall_rate_supported_out  out  1  stall feature compiled in.
- stall_rate_valid_in  in  1  load stall_rate_in.
- stall_rate_in  in  STALL_W  stall rate, N out of 8 cycles.

Behaviour:
- Reset (rst=0, async) clears all state:
  - rst_and_startup_done_out=0, rdy_out=0, empty_out=1, result_out=0.
  - FIFO pointers, pipeline valid and stall rate all cleared.
- Startup: after rst rises, a counter runs for STARTUP_CYCLES, then rst_and_startup_done_out=1 and stays high until the next reset.
- Accept condition: a call is accepted on a clk edge where valid_in && rdy_out.
- rdy_out = startup_done && (fifo_count + pipe_valid < FIFO_DEPTH) && !stall_now. It is registered-path safe and may depend only on state, never on valid_in.
- Compute: result = (x<<2) + x, truncated to 32 bits, with no saturation.
- Pipeline: one register stage. An accepted x is written into the FIFO on the next edge.
  - empty_out falls 2 cycles after acceptance.
  - Ordering is strictly FIFO.
- FIFO read port is show-ahead:
  - result_out is valid whenever empty_out=0.
  - rden_in && !empty_out pops at the edge; the next entry appears the following cycle.
  - rden_in while empty is ignored, with no underflow.
  - Simultaneous push and pop are legal at any occupancy, including full.
- The credit scheme guarantees the FIFO never overflows; no data is dropped.
- Reset mid-operation discards in-flight and queued results; startup repeats.

Optional Feature:
- Macro: EXPORTED_CLASS_METHOD_TEMPLATE_STALL_RATE_EN.
- Defined:
  - stall_rate_supported_out=1.
  - stall_rate_valid_in=1 latches stall_rate_in.
  - A free-running 3-bit counter cnt drives stall_now = (cnt < rate), which deasserts rdy_out in rate out of 8 cycles.
  - rate=0 means no stall.
- Undefined:
  - stall_rate_supported_out=0.
  - stall inputs are ignored and stall_now=0.

Decomposition:
- Package exported_class_method_template_pkg holds:
  - typedefs uint32_t and uint5_t;
  - constant TIMES_FIVE_MUL=5;
  - function times_five(uint32_t).
- One sub-module: ecmt_showahead_fifo, a parameterised depth/width FIFO with push, pop, empty, full and count.

Test Plan:
- Reset 10 cycles, release, wait for done; push x=0..9 back-to-back -> results 0,5,10,...,45 in order.
- x=0xFFFFFFFF -> 0xFFFFFFFB; x=0x33333334 -> 0x00000004 (wrap).
- No reads, push continuously -> exactly FIFO_DEPTH accepted, rdy_out low; pop one -> rdy_out rises, one more accepted; drain -> all values correct.
- rden_in pulsed while empty -> empty_out stays 1 and the next pushed x=7 still reads 35.
- Reset asserted with 5 queued results -> empty_out=1, rdy_out=0, done=0 immediately; after restart, push 3 -> read 15.
- With the macro defined: stall_rate=4 and valid_in held high over 800 cycles -> about 400 accepts, all results correct. Without the macro: stall_rate_supported_out=0 and no stalls.

Source files
------------

// File: rtl/exported_class_method_template_pkg.sv
// exported_class_method_template_pkg: shared types, constants and the TimesFive arithmetic.
package exported_class_method_template_pkg;

    typedef logic [31:0] uint32_t;
    typedef logic [4:0]  uint5_t;

    typedef enum logic {
        ST_STARTUP,
        ST_RUN
    } startup_state_e;

    localparam int TIMES_FIVE_MUL = 5;

    // Shift-and-add form of x*5; wraps modulo 2^32.
    function automatic uint32_t times_five(input uint32_t x);
        return (x << 2) + x;
    endfunction

endpackage

// File: rtl/ecmt_showahead_fifo.sv
// ecmt_showahead_fifo: power-of-two show-ahead FIFO; head data is visible whenever not empty.
module ecmt_showahead_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty   = r_count == '0;
    assign o_full    = r_count == (AW+1)'(DEPTH);
    assign o_count   = r_count;
    assign w_pop     = i_pop && !o_empty;
    // A push into a full FIFO is fine when the head leaves on the same edge.
    assign w_push    = i_push && (!o_full || w_pop);
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
            r_rd_ptr <= w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
            r_count  <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

// File: rtl/exported_class_method_template.sv
// exported_class_method_template: TimesFive(x)=x*5 call port feeding a show-ahead result FIFO.
// Stall injection is compiled in with EXPORTED_CLASS_METHOD_TEMPLATE_STALL_RATE_EN.
module exported_class_method_template
    import exported_class_method_template_pkg::*;
#(
    parameter int FIFO_DEPTH     = 32,
    parameter int STARTUP_CYCLES = 8,
    parameter int STALL_W        = 3
) (
    input  logic               clk,
    input  logic               rst,
    output logic               rst_and_startup_done_out,
    input  logic               TimesFive___uint_32___valid_in,
    input  logic [31:0]        TimesFive___uint_32___x_in,
    output logic               TimesFive___uint_32___rdy_out,
    input  logic               TimesFive___uint_32___rden_in,
    output logic               TimesFive___uint_32___empty_out,
    output logic [31:0]        TimesFive___uint_32___result_out,
    output logic               stall_rate_supported_out,
    input  logic               stall_rate_valid_in,
    input  logic [STALL_W-1:0] stall_rate_in
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(STARTUP_CYCLES + 1);

    startup_state_e r_state;
    startup_state_e w_state_nxt;
    logic [SW-1:0]  r_startup_cnt;
    logic           r_pipe_valid;
    uint32_t        r_pipe_data;
    logic [CW-1:0]  w_count;
    logic           w_full;
    logic           w_empty;
    logic           w_done;
    logic           w_credit_ok;
    logic           w_stall_now;
    logic           w_accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_STARTUP;
            r_startup_cnt <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_startup_cnt <= (r_state == ST_STARTUP) ? r_startup_cnt + 1'b1 : r_startup_cnt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_STARTUP && r_startup_cnt == SW'(STARTUP_CYCLES - 1))
            w_state_nxt = ST_RUN;
    end

    assign w_done = r_state == ST_RUN;

    // Credits cover both queued results and the one in the pipeline register.
    assign w_credit_ok = (int'(w_count) + int'(r_pipe_valid)) < FIFO_DEPTH;
    assign w_accept    = TimesFive___uint_32___valid_in && TimesFive___uint_32___rdy_out;

`ifdef EXPORTED_CLASS_METHOD_TEMPLATE_STALL_RATE_EN
    logic [2:0]         r_stall_cnt;
    logic [STALL_W-1:0] r_stall_rate;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt  <= '0;
            r_stall_rate <= '0;
        end else begin
            r_stall_cnt  <= r_stall_cnt + 3'd1;
            r_stall_rate <= stall_rate_valid_in ? stall_rate_in : r_stall_rate;
        end
    end

    assign w_stall_now              = int'(r_stall_cnt) < int'(r_stall_rate);
    assign stall_rate_supported_out = 1'b1;
`else
    logic w_unused_stall;

    assign w_unused_stall           = stall_rate_valid_in ^ (^stall_rate_in);
    assign w_stall_now              = 1'b0;
    assign stall_rate_supported_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pipe_valid <= 1'b0;
            r_pipe_data  <= '0;
        end else begin
            r_pipe_valid <= w_accept;
            r_pipe_data  <= w_accept ? times_five(TimesFive___uint_32___x_in) : r_pipe_data;
        end
    end

    ecmt_showahead_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .i_push    (r_pipe_valid),
        .i_wr_data (r_pipe_data),
        .i_pop     (TimesFive___uint_32___rden_in),
        .o_rd_data (TimesFive___uint_32___result_out),
        .o_empty   (w_empty),
        .o_full    (w_full),
        .o_count   (w_count)
    );

    assign rst_and_startup_done_out        = w_done;
    assign TimesFive___uint_32___rdy_out   = w_done && w_credit_ok && !w_stall_now;
    assign TimesFive___uint_32___empty_out = w_empty;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(w_full && r_pipe_valid && !TimesFive___uint_32___rden_in));

endmodule

// File: tb/tb_exported_class_method_template.sv
// tb_exported_class_method_template: table vectors, corner sequences and random traffic vs a queue model.
module tb_exported_class_method_template;

    localparam int DEPTH   = 32;
    localparam int STARTUP = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        done;
    logic        valid_in = 1'b0;
    logic [31:0] x_in = '0;
    logic        rdy;
    logic        rden = 1'b0;
    logic        empty;
    logic [31:0] result;
    logic        supported;
    logic        srv = 1'b0;
    logic [2:0]  sr = '0;

    typedef struct {
        logic [31:0] v;
        int          t;
    } item_t;

    typedef struct {
        logic [31:0] x;
        logic [31:0] exp;
    } vec_t;

    item_t q[$];
    vec_t  vecs[14];
    int    tests = 0;
    int    fails = 0;
    int    edges = 0;
    int    now = 0;
    int    accepts = 0;
    int    a0;
    bit    stalling = 0;

    exported_class_method_template dut (
        .clk                              (clk),
        .rst                              (rst),
        .rst_and_startup_done_out         (done),
        .TimesFive___uint_32___valid_in   (valid_in),
        .TimesFive___uint_32___x_in       (x_in),
        .TimesFive___uint_32___rdy_out    (rdy),
        .TimesFive___uint_32___rden_in    (rden),
        .TimesFive___uint_32___empty_out  (empty),
        .TimesFive___uint_32___result_out (result),
        .stall_rate_supported_out         (supported),
        .stall_rate_valid_in              (srv),
        .stall_rate_in                    (sr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cyc(input logic v, input logic [31:0] x, input logic rd);
        logic  done_exp;
        logic  empty_exp;
        item_t it;
        valid_in  = v;
        x_in      = x;
        rden      = rd;
        done_exp  = edges >= STARTUP;
        empty_exp = (q.size() == 0) ? 1'b1 : ((now - q[0].t) < 2);
        chk("done", 32'(done), 32'(done_exp));
        if (!stalling)
            chk("rdy", 32'(rdy), 32'(done_exp && q.size() < DEPTH));
        else
            chk("rdy_credit", 32'(rdy && !(done_exp && q.size() < DEPTH)), 32'd0);
        chk("empty", 32'(empty), 32'(empty_exp));
        if (!empty_exp)
            chk("result", result, q[0].v);
        if (v && rdy) begin
            it.v = x * 32'd5;
            it.t = now;
            q.push_back(it);
            accepts++;
        end
        if (rd && !empty && q.size() > 0)
            void'(q.pop_front());
        @(negedge clk);
        edges++;
        now++;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        valid_in = 1'b0;
        rden     = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdy", 32'(rdy), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_result", result, 32'd0);
        q.delete();
        rst   = 1'b1;
        edges = 0;
        repeat (STARTUP) cyc(1'b0, '0, 1'b0);
        chk("startup_done", 32'(done), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 200) begin
            cyc(1'b0, '0, 1'b1);
            n++;
        end
        chk("drain_left", 32'(q.size()), 32'd0);
        chk("drain_empty", 32'(empty), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 10; i++) begin
            vecs[i].x   = 32'(i);
            vecs[i].exp = 32'(i * 5);
        end
        vecs[10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFB};
        vecs[11] = '{32'h3333_3334, 32'h0000_0004};
        vecs[12] = '{32'h8000_0000, 32'h8000_0000};
        vecs[13] = '{32'h1234_5678, 32'h5B05_B058};

        do_reset();

        for (int i = 0; i < 14; i++) cyc(1'b1, vecs[i].x, 1'b0);
        chk("vec_accepts", 32'(accepts), 32'd14);
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0);
        for (int i = 0; i < 14; i++) begin
            chk("vec_result", result, vecs[i].exp);
            cyc(1'b0, '0, 1'b1);
        end
        chk("vec_empty", 32'(empty), 32'd1);

        a0 = accepts;
        for (int i = 0; i < 40; i++) cyc(1'b1, 32'(1000 + i), 1'b0);
        chk("full_accepts", 32'(accepts - a0), 32'd32);
        chk("full_rdy", 32'(rdy), 32'd0);
        cyc(1'b1, 32'd2000, 1'b1);
        chk("rdy_after_pop", 32'(rdy), 32'd1);
        cyc(1'b1, 32'd2001, 1'b0);
        cyc(1'b1, 32'd2002, 1'b0);
        chk("one_more_accept", 32'(accepts - a0), 32'd33);
        drain();

        repeat (3) begin
            cyc(1'b0, '0, 1'b1);
            chk("empty_read", 32'(empty), 32'd1);
        end
        cyc(1'b1, 32'd7, 1'b0);
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0);
        chk("after_underflow", result, 32'd35);
        cyc(1'b0, '0, 1'b1);

        for (int i = 0; i < 5; i++) cyc(1'b1, 32'(100 + i), 1'b0);
        repeat (3) cyc(1'b0, '0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_rdy", 32'(rdy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_result", result, 32'd0);
        do_reset();
        cyc(1'b1, 32'd3, 1'b0);
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0);
        chk("restart_result", result, 32'd15);
        cyc(1'b0, '0, 1'b1);

        repeat (400) cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0);
        repeat (300) cyc($urandom_range(0, 1) != 0, $urandom, $urandom_range(0, 3) != 0);
        drain();

`ifdef EXPORTED_CLASS_METHOD_TEMPLATE_STALL_RATE_EN
        chk("supported", 32'(supported), 32'd1);
        srv = 1'b1;
        sr  = 3'd4;
        cyc(1'b0, '0, 1'b0);
        srv      = 1'b0;
        stalling = 1;
        a0 = accepts;
        repeat (800) cyc(1'b1, $urandom, 1'b1);
        tests++;
        if (accepts - a0 < 390 || accepts - a0 > 410) begin
            fails++;
            $display("FAIL stall_accepts: got %0d expected about 400", accepts - a0);
        end
        srv = 1'b1;
        sr  = 3'd0;
        cyc(1'b0, '0, 1'b1);
        srv      = 1'b0;
        stalling = 0;
`else
        chk("supported", 32'(supported), 32'd0);
        srv = 1'b1;
        sr  = 3'd4;
        cyc(1'b0, '0, 1'b0);
        srv = 1'b0;
        a0  = accepts;
        repeat (100) cyc(1'b1, $urandom, 1'b1);
        chk("nostall_accepts", 32'(accepts - a0), 32'd100);
`endif
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
